// File: rtl/fetch_unit.sv
// Prefetching instruction-fetch front end: one outstanding memory request at a
// time, a PC-tagged FIFO toward decode, branch redirect/flush and halt/drain.
module fetch_unit #(
  parameter int unsigned         PC_WIDTH    = 12,
  parameter int unsigned         INSTR_WIDTH = 9,
  parameter int unsigned         DEPTH       = 4,
  parameter logic [PC_WIDTH-1:0] RESET_PC    = '0
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic                   halt,
  input  logic                   redirect,
  input  logic [PC_WIDTH-1:0]    redirect_pc,
  output logic                   imem_req,
  output logic [PC_WIDTH-1:0]    imem_addr,
  input  logic                   imem_ack,
  input  logic [INSTR_WIDTH-1:0] imem_data,
  output logic                   instr_valid,
  output logic [INSTR_WIDTH-1:0] instr,
  output logic [PC_WIDTH-1:0]    instr_pc,
  input  logic                   instr_ready,
  output logic                   busy,
  output logic                   done
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_HALTED} state_e;

  typedef struct packed {
    logic [PC_WIDTH-1:0]    pc;
    logic [INSTR_WIDTH-1:0] word;
  } entry_t;

  state_e              state_q, state_d;
  logic [PC_WIDTH-1:0] fetch_pc_q, fetch_pc_d;
  logic [PC_WIDTH-1:0] addr_q, addr_d;
  logic                req_q, req_d;
  logic                squash_q, squash_d;
  logic                valid_q, valid_d;
  logic                busy_q, done_q;
  logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]    count_q, count_d;
  entry_t              head_q, head_d;
  entry_t              new_c;
  entry_t              mem_q [DEPTH];

  logic run_c, xfer_c, flush_c, push_c, pop_c;

  assign run_c   = (state_q == S_RUN);
  assign xfer_c  = req_q && imem_ack;
  assign flush_c = run_c && (halt || redirect);
  assign push_c  = xfer_c && run_c && !flush_c && !squash_q;
  assign pop_c   = valid_q && instr_ready && !flush_c;
  assign new_c   = '{pc: addr_q, word: imem_data};

  // Next-state: FIFO bookkeeping first, since the request decision needs count_d
  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    addr_d     = addr_q;
    req_d      = req_q;
    squash_d   = squash_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    head_d     = head_q;

    if (flush_c) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_c) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop_c)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      count_d = count_q + CNT_W'(push_c) - CNT_W'(pop_c);
    end

    // The new head is the word being written this edge when it lands at the read slot
    if (count_d != '0) begin
      if (push_c && (wr_ptr_q == rd_ptr_d)) head_d = new_c;
      else                                  head_d = mem_q[rd_ptr_d];
    end
    valid_d = (count_d != '0);

    case (state_q)
      S_IDLE, S_HALTED: begin
        if (start) begin
          state_d    = S_RUN;
          fetch_pc_d = RESET_PC;
          addr_d     = RESET_PC;
          req_d      = 1'b1;
          squash_d   = 1'b0;
        end
      end
      S_RUN: begin
        if (halt) begin
          state_d  = S_DRAIN;
          req_d    = req_q && !imem_ack;
          squash_d = req_q && !imem_ack;
        end else begin
          if (redirect)                 fetch_pc_d = redirect_pc;
          else if (xfer_c && !squash_q) fetch_pc_d = fetch_pc_q + PC_WIDTH'(1);
          // A request still waiting for its ack keeps its address; a redirect marks it stale
          if (req_q && !imem_ack) begin
            squash_d = squash_q || redirect;
          end else begin
            squash_d = 1'b0;
            req_d    = (count_d < CNT_W'(DEPTH));
            if (req_d) addr_d = fetch_pc_d;
          end
        end
      end
      S_DRAIN: begin
        if (!req_q || imem_ack) begin
          state_d  = S_HALTED;
          req_d    = 1'b0;
          squash_d = 1'b0;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      fetch_pc_q <= RESET_PC;
      addr_q     <= '0;
      req_q      <= 1'b0;
      squash_q   <= 1'b0;
      valid_q    <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      head_q     <= '0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      addr_q     <= addr_d;
      req_q      <= req_d;
      squash_q   <= squash_d;
      valid_q    <= valid_d;
      busy_q     <= (state_d == S_RUN) || (state_d == S_DRAIN);
      done_q     <= (state_d == S_HALTED);
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      head_q     <= head_d;
    end
  end

  // Storage is only observed through the reset head register, so it carries no reset
  always_ff @(posedge clk) begin
    if (push_c) mem_q[wr_ptr_q] <= new_c;
  end

  assign imem_req    = req_q;
  assign imem_addr   = addr_q;
  assign instr_valid = valid_q;
  assign instr       = head_q.word;
  assign instr_pc    = head_q.pc;
  assign busy        = busy_q;
  assign done        = done_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: vector table for stream/backpressure/redirect/halt,
// plus hand sequences for pending redirect, pending halt, PC wrap and async reset.
module tb_fetch_unit;

  localparam int unsigned PW = 12;
  localparam int unsigned IW = 9;
  localparam int unsigned D  = 4;

  logic          clk;
  logic          reset;
  logic          start, halt, redirect, instr_ready;
  logic [PW-1:0] redirect_pc;
  logic          imem_req, imem_ack, instr_valid, busy, done;
  logic [PW-1:0] imem_addr, instr_pc;
  logic [IW-1:0] imem_data, instr;

  logic          imem_req2, instr_valid2, busy2, done2;
  logic [PW-1:0] imem_addr2, instr_pc2;
  logic [IW-1:0] imem_data2, instr2;

  int wait_n;
  int wcnt;
  int n_pass, n_total, n_ovf;

  fetch_unit #(.PC_WIDTH(PW), .INSTR_WIDTH(IW), .DEPTH(D), .RESET_PC(12'h000)) dut (
    .clk(clk), .reset(reset), .start(start), .halt(halt), .redirect(redirect),
    .redirect_pc(redirect_pc), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_data(imem_data), .instr_valid(instr_valid),
    .instr(instr), .instr_pc(instr_pc), .instr_ready(instr_ready),
    .busy(busy), .done(done)
  );

  fetch_unit #(.PC_WIDTH(PW), .INSTR_WIDTH(IW), .DEPTH(D), .RESET_PC(12'hFFE)) dut2 (
    .clk(clk), .reset(reset), .start(start), .halt(halt), .redirect(redirect),
    .redirect_pc(redirect_pc), .imem_req(imem_req2), .imem_addr(imem_addr2),
    .imem_ack(1'b1), .imem_data(imem_data2), .instr_valid(instr_valid2),
    .instr(instr2), .instr_pc(instr_pc2), .instr_ready(instr_ready),
    .busy(busy2), .done(done2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory model: word = address, ack after wait_n wait cycles
  assign imem_data  = IW'(imem_addr);
  assign imem_data2 = IW'(imem_addr2);
  assign imem_ack   = imem_req && (wcnt >= wait_n);

  always @(posedge clk or negedge reset) begin
    if (!reset)                      wcnt <= 0;
    else if (imem_req && !imem_ack)  wcnt <= wcnt + 1;
    else                             wcnt <= 0;
  end

  always @(posedge clk) begin
    if (reset && dut.push_c && (dut.count_q >= 3'(D))) begin
      $display("FAIL fifo_push_when_full dut count=%0d", dut.count_q);
      n_ovf++;
    end
    if (reset && dut2.push_c && (dut2.count_q >= 3'(D))) begin
      $display("FAIL fifo_push_when_full dut2 count=%0d", dut2.count_q);
      n_ovf++;
    end
  end

  typedef struct {
    logic          start, halt, redir;
    logic [PW-1:0] rpc;
    logic          ready;
    logic          e_req;
    logic [PW-1:0] e_addr;
    logic          e_valid;
    logic [PW-1:0] e_pc;
    logic          e_busy, e_done;
  } vec_t;

  localparam int unsigned NV = 19;
  vec_t tv [NV];

  function automatic vec_t mk(input logic s, input logic h, input logic r, input logic [PW-1:0] rpc,
                              input logic rdy, input logic er, input logic [PW-1:0] ea,
                              input logic ev, input logic [PW-1:0] ep, input logic eb, input logic ed);
    vec_t v;
    v.start = s; v.halt = h; v.redir = r; v.rpc = rpc; v.ready = rdy;
    v.e_req = er; v.e_addr = ea; v.e_valid = ev; v.e_pc = ep; v.e_busy = eb; v.e_done = ed;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_total++;
    if (act === expv) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, expv);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    start = 1'b0; halt = 1'b0; redirect = 1'b0; redirect_pc = '0; instr_ready = 1'b0;
    step();
    step();
    reset = 1'b1;
  endtask

  logic          found, held_ok, acked, have_new, got, seen5;
  logic [PW-1:0] new_addr, first_pc, e_a;
  int            req_cycles;

  initial begin
    n_pass = 0; n_total = 0; n_ovf = 0;
    wait_n = 0;
    start = 1'b0; halt = 1'b0; redirect = 1'b0; redirect_pc = '0; instr_ready = 1'b0;
    reset = 1'b1;
    #2 reset = 1'b0;
    step();

    chk("rst_req",   32'(imem_req),    32'd0);
    chk("rst_addr",  32'(imem_addr),   32'd0);
    chk("rst_valid", 32'(instr_valid), 32'd0);
    chk("rst_instr", 32'(instr),       32'd0);
    chk("rst_pc",    32'(instr_pc),    32'd0);
    chk("rst_busy",  32'(busy),        32'd0);
    chk("rst_done",  32'(done),        32'd0);
    chk("rst_addr2", 32'(imem_addr2),  32'd0);
    reset = 1'b1;

    //            s     h     r     rpc      rdy   req   addr     vld   pc       busy  done
    tv[0]  = mk(1'b1, 1'b0, 1'b0, 12'h000, 1'b0, 1'b1, 12'h000, 1'b0, 12'h000, 1'b1, 1'b0);
    tv[1]  = mk(1'b0, 1'b0, 1'b0, 12'h000, 1'b0, 1'b1, 12'h001, 1'b1, 12'h000, 1'b1, 1'b0);
    tv[2]  = mk(1'b0, 1'b0, 1'b0, 12'h000, 1'b0, 1'b1, 12'h002, 1'b1, 12'h000, 1'b1, 1'b0);
    tv[3]  = mk(1'b0, 1'b0, 1'b0, 12'h000, 1'b0, 1'b1, 12'h003, 1'b1, 12'h000, 1'b1, 1'b0);
    tv[4]  = mk(1'b0, 1'b0, 1'b0, 12'h000, 1'b0, 1'b0, 12'h000, 1'b1, 12'h000, 1'b1, 1'b0);
    tv[5]  = mk(1'b0, 1'b0, 1'b0, 12'h000, 1'b0, 1'b0, 12'h000, 1'b1, 12'h000, 1'b1, 1'b0);
    tv[6]  = mk(1'b0, 1'b0, 1'b0, 12'h000, 1'b1, 1'b1, 12'h004, 1'b1, 12'h001, 1'b1, 1'b0);
    tv[7]  = mk(1'b0, 1'b0, 1'b0, 12'h000, 1'b1, 1'b1, 12'h005, 1'b1, 12'h002, 1'b1, 1'b0);
    tv[8]  = mk(1'b0, 1'b0, 1'b0, 12'h000, 1'b1, 1'b1, 12'h006, 1'b1, 12'h003, 1'b1, 1'b0);
    tv[9]  = mk(1'b0, 1'b0, 1'b0, 12'h000, 1'b1, 1'b1, 12'h007, 1'b1, 12'h004, 1'b1, 1'b0);
    tv[10] = mk(1'b0, 1'b0, 1'b0, 12'h000, 1'b1, 1'b1, 12'h008, 1'b1, 12'h005, 1'b1, 1'b0);
    tv[11] = mk(1'b0, 1'b0, 1'b1, 12'h040, 1'b1, 1'b1, 12'h040, 1'b0, 12'h000, 1'b1, 1'b0);
    tv[12] = mk(1'b0, 1'b0, 1'b0, 12'h000, 1'b1, 1'b1, 12'h041, 1'b1, 12'h040, 1'b1, 1'b0);
    tv[13] = mk(1'b0, 1'b0, 1'b0, 12'h000, 1'b1, 1'b1, 12'h042, 1'b1, 12'h041, 1'b1, 1'b0);
    tv[14] = mk(1'b0, 1'b1, 1'b1, 12'h080, 1'b1, 1'b0, 12'h000, 1'b0, 12'h000, 1'b1, 1'b0);
    tv[15] = mk(1'b0, 1'b0, 1'b0, 12'h000, 1'b1, 1'b0, 12'h000, 1'b0, 12'h000, 1'b0, 1'b1);
    tv[16] = mk(1'b0, 1'b0, 1'b1, 12'h020, 1'b1, 1'b0, 12'h000, 1'b0, 12'h000, 1'b0, 1'b1);
    tv[17] = mk(1'b1, 1'b0, 1'b0, 12'h000, 1'b1, 1'b1, 12'h000, 1'b0, 12'h000, 1'b1, 1'b0);
    tv[18] = mk(1'b0, 1'b0, 1'b0, 12'h000, 1'b1, 1'b1, 12'h001, 1'b1, 12'h000, 1'b1, 1'b0);

    for (int i = 0; i < int'(NV); i++) begin
      start = tv[i].start; halt = tv[i].halt; redirect = tv[i].redir;
      redirect_pc = tv[i].rpc; instr_ready = tv[i].ready;
      step();
      chk($sformatf("vec%0d_req", i),   32'(imem_req),    32'(tv[i].e_req));
      chk($sformatf("vec%0d_valid", i), 32'(instr_valid), 32'(tv[i].e_valid));
      chk($sformatf("vec%0d_busy", i),  32'(busy),        32'(tv[i].e_busy));
      chk($sformatf("vec%0d_done", i),  32'(done),        32'(tv[i].e_done));
      if (tv[i].e_req) chk($sformatf("vec%0d_addr", i), 32'(imem_addr), 32'(tv[i].e_addr));
      if (tv[i].e_valid) begin
        chk($sformatf("vec%0d_pc", i),    32'(instr_pc), 32'(tv[i].e_pc));
        chk($sformatf("vec%0d_instr", i), 32'(instr),    32'(IW'(tv[i].e_pc)));
      end
    end
    start = 1'b0; halt = 1'b0; redirect = 1'b0;

    // Redirect while the request to address 5 is waiting on a slow memory
    do_reset();
    wait_n = 3; instr_ready = 1'b1;
    start = 1'b1; step(); start = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 200 && !found; i++) begin
      if (imem_req && imem_addr == 12'h005 && !imem_ack) found = 1'b1;
      else step();
    end
    chk("redir_setup", 32'(found), 32'd1);
    redirect = 1'b1; redirect_pc = 12'h100;
    step();
    redirect = 1'b0; redirect_pc = '0;
    chk("redir_flush_valid", 32'(instr_valid), 32'd0);
    chk("redir_hold_req",    32'(imem_req),    32'd1);
    chk("redir_hold_addr",   32'(imem_addr),   32'h005);
    held_ok = 1'b1; acked = 1'b0; have_new = 1'b0; got = 1'b0; seen5 = 1'b0;
    new_addr = '0; first_pc = '0;
    for (int i = 0; i < 40 && !got; i++) begin
      if (instr_valid && instr_pc == 12'h005) seen5 = 1'b1;
      if (instr_valid) begin got = 1'b1; first_pc = instr_pc; end
      if (imem_req) begin
        if (!acked) begin
          if (imem_addr != 12'h005) held_ok = 1'b0;
          if (imem_ack) acked = 1'b1;
        end else if (!have_new) begin
          have_new = 1'b1; new_addr = imem_addr;
        end
      end
      if (!got) step();
    end
    chk("redir_addr_held",  32'(held_ok),  32'd1);
    chk("redir_old_acked",  32'(acked),    32'd1);
    chk("redir_next_addr",  32'(new_addr), 32'h100);
    chk("redir_got_instr",  32'(got),      32'd1);
    chk("redir_first_pc",   32'(first_pc), 32'h100);
    chk("redir_squashed5",  32'(seen5),    32'd0);

    // Halt while a request is pending, then restart
    do_reset();
    wait_n = 3; instr_ready = 1'b1;
    start = 1'b1; step(); start = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 100 && !found; i++) begin
      if (imem_req && imem_addr == 12'h002 && !imem_ack) found = 1'b1;
      else step();
    end
    chk("halt_setup", 32'(found), 32'd1);
    halt = 1'b1;
    step();
    halt = 1'b0;
    chk("halt_valid", 32'(instr_valid), 32'd0);
    chk("halt_busy",  32'(busy),        32'd1);
    chk("halt_done",  32'(done),        32'd0);
    chk("halt_req",   32'(imem_req),    32'd1);
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      if (imem_ack) found = 1'b1;
      else step();
    end
    chk("halt_ack_seen", 32'(found), 32'd1);
    step();
    chk("halted_done",  32'(done),        32'd1);
    chk("halted_busy",  32'(busy),        32'd0);
    chk("halted_req",   32'(imem_req),    32'd0);
    chk("halted_valid", 32'(instr_valid), 32'd0);
    step();
    chk("halted_done_hold", 32'(done), 32'd1);
    start = 1'b1; step(); start = 1'b0;
    chk("restart_req",  32'(imem_req),  32'd1);
    chk("restart_addr", 32'(imem_addr), 32'h000);
    chk("restart_done", 32'(done),      32'd0);
    chk("restart_busy", 32'(busy),      32'd1);
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      if (instr_valid) got = 1'b1;
      else step();
    end
    chk("restart_got", 32'(got),      32'd1);
    chk("restart_pc",  32'(instr_pc), 32'h000);

    // PC wrap on the instance starting at 0xFFE with ack tied high
    do_reset();
    wait_n = 0; instr_ready = 1'b1;
    start = 1'b1; step(); start = 1'b0;
    for (int k = 0; k < 4; k++) begin
      e_a = 12'hFFE + 12'(k);
      chk($sformatf("wrap_req%0d", k),  32'(imem_req2),  32'd1);
      chk($sformatf("wrap_addr%0d", k), 32'(imem_addr2), 32'(e_a));
      if (k > 0) begin
        e_a = 12'hFFE + 12'(k - 1);
        chk($sformatf("wrap_valid%0d", k), 32'(instr_valid2), 32'd1);
        chk($sformatf("wrap_pc%0d", k),    32'(instr_pc2),    32'(e_a));
        chk($sformatf("wrap_instr%0d", k), 32'(instr2),       32'(IW'(e_a)));
      end
      step();
    end

    // Asynchronous reset between edges while a request is outstanding
    do_reset();
    wait_n = 3; instr_ready = 1'b1;
    start = 1'b1; step(); start = 1'b0;
    step();
    chk("arst_pre_req", 32'(imem_req), 32'd1);
    #3 reset = 1'b0;
    #1;
    chk("arst_req",   32'(imem_req),    32'd0);
    chk("arst_addr",  32'(imem_addr),   32'd0);
    chk("arst_valid", 32'(instr_valid), 32'd0);
    chk("arst_instr", 32'(instr),       32'd0);
    chk("arst_pc",    32'(instr_pc),    32'd0);
    chk("arst_busy",  32'(busy),        32'd0);
    chk("arst_done",  32'(done),        32'd0);
    step();
    reset = 1'b1;
    req_cycles = 0;
    for (int i = 0; i < 6; i++) begin
      step();
      if (imem_req) req_cycles++;
    end
    chk("arst_no_req", 32'(req_cycles), 32'd0);
    chk("arst_idle_busy", 32'(busy), 32'd0);
    start = 1'b1; step(); start = 1'b0;
    chk("arst_restart_req",  32'(imem_req),  32'd1);
    chk("arst_restart_addr", 32'(imem_addr), 32'h000);
    step();

    $display("%0d/%0d checks passed", n_pass, n_total + n_ovf);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Parametrised instruction-fetch front end for the next-generation core. It replaces the bare program counter plus combinational instruction-memory read with a prefetching fetch engine. The engine issues one-at-a-time requests to a variable-latency instruction memory and buffers fetched words in a DEPTH-entry FIFO tagged with their PC. It hands instructions to decode over a valid/ready handshake and supports branch redirect/flush and halt/drain. The unit sits between instruction memory and the controller/decode stage.

## Interface
- PC_WIDTH, 12, fetch address width; PC arithmetic wraps modulo 2^PC_WIDTH.
- INSTR_WIDTH, 9, instruction word width.
- DEPTH, 4, prefetch FIFO entries; power of two, ≥ 2.
- RESET_PC, 0, first fetch address after start.
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  pulse; begins fetching from RESET_PC when IDLE or HALTED, ignored otherwise.
- halt  in  1  pulse from controller done; stop fetching and drain.
- redirect  in  1  pulse; taken branch, flush and refetch.
- redirect_pc  in  PC_WIDTH  branch target, sampled when redirect=1.
- imem_req  out  1  fetch request.
- imem_addr  out  PC_WIDTH  request address.
- imem_ack  in  1  request accepted, imem_data valid this cycle.
- imem_data  in  INSTR_WIDTH  fetched word.
- instr_valid  out  1  FIFO head valid.
- instr  out  INSTR_WIDTH  FIFO head word.
- instr_pc  out  PC_WIDTH  PC of FIFO head.
- instr_ready  in  1  decode consumes head.
- busy  out  1  state is RUN or DRAIN.
- done  out  1  state is HALTED.

## Operation
- States: IDLE → (start) RUN → (halt) DRAIN → (no request outstanding) HALTED → (start) RUN.
- RUN fetch rules:
  - imem_req=1 whenever FIFO count + outstanding(0/1) < DEPTH.
  - At most one request is outstanding.
  - imem_req and imem_addr are held stable until imem_ack.
- Transfer on an edge with imem_req && imem_ack:
  - push {imem_data, imem_addr} into the FIFO (unless squashed);
  - fetch_pc ← fetch_pc + 1.
- Pop on an edge with instr_valid && instr_ready. Simultaneous push and pop leaves count unchanged. Push into a full FIFO cannot occur by construction; the bench asserts this.
- Redirect in RUN:
  - FIFO flushed, so instr_valid=0 from the next cycle.
  - fetch_pc ← redirect_pc.
  - If a request is pending and not acked this cycle, it stays asserted at its old address until ack. Its data is discarded (squash flag), and then fetching resumes at redirect_pc.
  - If ack coincides with redirect, that word is discarded.
- Halt in RUN: FIFO flushed, no new requests, enter DRAIN. A pending request completes and its data is discarded. DRAIN → HALTED on the edge where nothing is outstanding, or immediately if nothing was pending.
- Halt and redirect in the same cycle: halt wins. Redirect is ignored in IDLE, DRAIN and HALTED.
- start in HALTED restarts at RESET_PC with the FIFO empty.

## Timing
- Reset (reset=0): asynchronous.
  - State IDLE.
  - imem_req, instr_valid, busy and done = 0.
  - imem_addr, instr and instr_pc = 0.
  - fetch_pc = RESET_PC.
  - FIFO empty, squash flag clear.
  - Reset mid-transaction abandons the request; imem_req drops immediately.
- start sampled at edge E: imem_req=1 with imem_addr=RESET_PC in cycle E+1.
- imem_ack may arrive in the same cycle as imem_req (zero-wait memory).
- Ack at edge A: instr_valid=1 from cycle A+1. There is no combinational bypass from imem_data to instr.
- Back-to-back: after an ack, the next request (fetch_pc+1) is presented in the following cycle if there is room. Zero-wait memory therefore sustains one instruction per cycle.
- Redirect at edge R with no pending request: request to redirect_pc in cycle R+1.
- FIFO outputs are registered head values, stable while instr_valid=1 and instr_ready=0.
- done asserts the cycle after the DRAIN→HALTED edge and holds until start or reset.

## Test plan
- Zero-wait stream: reset, start, ack tied high, instr_ready=1, memory word = address → instr_pc 0,1,2,3… on consecutive cycles from 2 cycles after start.
- Backpressure: instr_ready=0, ack high →
  - exactly DEPTH=4 transfers (addresses 0–3), then imem_req=0;
  - raising ready drains 0–3 in order, then fetching resumes at 4.
- Redirect with pending request: memory acks after 3 wait cycles; redirect_pc=0x100 while addr 5 is pending →
  - addr 5 held until ack and its word is never presented;
  - next request is 0x100; first instr_pc after the redirect is 0x100.
- Halt/drain: halt while a request is pending →
  - instr_valid=0 next cycle;
  - done=1 one cycle after ack, busy=0;
  - a subsequent start refetches from 0.
- PC wrap: RESET_PC=0xFFE, ack high → addresses 0xFFE, 0xFFF, 0x000, 0x001.
- Async reset mid-fetch: reset low between edges while imem_req=1 → all outputs 0 immediately; no further requests until the next start.
